iterative_alu: RTL

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/iterative_alu_pkg.sv | 47 ++++
 rtl/iterative_alu_if.sv | 27 ++
 rtl/iterative_muldiv_core.sv | 86 ++++++++
 rtl/iterative_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/iterative_alu_pkg.sv
// Shared constants for the iterative ALU: FunSel field positions, op codes,
// flag bit positions and the controller state encoding.
package iterative_alu_pkg;

  // FunSel field positions
  localparam int FS_GROUP = 5;
  localparam int FS_WIDTH = 4;

  // FlagsOut bit positions, {Z,C,N,O} from MSB to LSB
  localparam int FL_Z = 3;
  localparam int FL_C = 2;
  localparam int FL_N = 1;
  localparam int FL_O = 0;

  // Single-cycle group (FunSel[5] = 0)
  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_PASS_B = 4'd1;
  localparam logic [3:0] OP_NOT_A  = 4'd2;
  localparam logic [3:0] OP_NOT_B  = 4'd3;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_ADC    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_AND    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_XOR    = 4'd9;
  localparam logic [3:0] OP_NAND   = 4'd10;
  localparam logic [3:0] OP_LSL    = 4'd11;
  localparam logic [3:0] OP_LSR    = 4'd12;
  localparam logic [3:0] OP_ASR    = 4'd13;
  localparam logic [3:0] OP_CSL    = 4'd14;
  localparam logic [3:0] OP_CSR    = 4'd15;

  // Multi-cycle group (FunSel[5] = 1); every other code is reserved
  localparam logic [3:0] OP_MUL = 4'd0;
  localparam logic [3:0] OP_DIV = 4'd1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Two's-complement overflow of a sum given operand and result sign bits.
  function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bundle of the iterative ALU.
// Handshake: Start is sampled only on an edge where Busy=0 (ignored otherwise);
// Done is a one-cycle pulse on the cycle ALUOut/HiOut/FlagsOut take new values.
interface iterative_alu_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [5:0]       FunSel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             WF;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] HiOut;
  logic [3:0]       FlagsOut;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, FunSel, A, B, WF,
    input  ALUOut, HiOut, FlagsOut, Busy, Done
  );

  modport slave (
    input  Start, FunSel, A, B, WF,
    output ALUOut, HiOut, FlagsOut, Busy, Done
  );
endinterface

// File: rtl/iterative_muldiv_core.sv
// One-bit-per-cycle unsigned multiply (shift-add) and restoring divide.
// Operands arrive already masked to the effective width; results are exposed
// for the step in progress so the owner can capture them on the final step.
module iterative_muldiv_core #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic             run,
  input  logic             div_sel,
  input  logic             half,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_r, b_r, quo, rem, quo_n, rem_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]      cnt, top_idx, bit_idx;
  logic [WIDTH:0]     r_sh;
  logic               div_r, half_r, q_bit;

  // Both algorithms consume operand bits MSB first, so the same index
  // walks the multiplier (b) and the dividend (a).
  assign top_idx = half_r ? CW'(HW - 1) : CW'(WIDTH - 1);
  assign bit_idx = top_idx - cnt;
  assign last    = run && (cnt == top_idx);

  always_comb begin
    acc_n = acc << 1;
    if (b_r[bit_idx]) begin
      acc_n = acc_n + {{WIDTH{1'b0}}, a_r};
    end

    r_sh  = {rem, a_r[bit_idx]};
    q_bit = (r_sh >= {1'b0, b_r});
    rem_n = q_bit ? (r_sh[WIDTH-1:0] - b_r) : r_sh[WIDTH-1:0];
    quo_n = (quo << 1) | {{(WIDTH-1){1'b0}}, q_bit};

    res_lo = '0;
    res_hi = '0;
    if (div_r) begin
      res_lo = quo_n;
      res_hi = rem_n;
    end else if (half_r) begin
      res_lo = {{HW{1'b0}}, acc_n[HW-1:0]};
      res_hi = {{HW{1'b0}}, acc_n[WIDTH-1:HW]};
    end else begin
      res_lo = acc_n[WIDTH-1:0];
      res_hi = acc_n[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_r    <= '0;
      b_r    <= '0;
      div_r  <= 1'b0;
      half_r <= 1'b0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else if (load) begin
      a_r    <= a;
      b_r    <= b;
      div_r  <= div_sel;
      half_r <= half;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc <= acc_n;
      quo <= quo_n;
      rem <= rem_n;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Iterative ALU top: single-cycle ops, flag register, Start/Busy/Done
// handshake and the IDLE/RUN controller around the multiply/divide core.
module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  iterative_alu_if.slave       bus,
  output state_t               dbg_state
);
  localparam int HW = WIDTH / 2;
  localparam logic [WIDTH-1:0] LO_MASK  = {{HW{1'b0}}, {HW{1'b1}}};
  localparam logic [WIDTH-1:0] LO_MSB   = WIDTH'(1) << (HW - 1);
  localparam logic [WIDTH-1:0] FULL_MSB = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] alu_q, hi_q;
  logic [3:0]       flags_q;
  logic             done_q, wf_r, div_r, half_r;

  logic             half, grp, md_valid, is_div0, is_reserved;
  logic             start_run, finish_now, run_done, hi_nz;
  logic [3:0]       op;
  logic [WIDTH-1:0] mask, msb, a_m, b_m, sc_res, run_msb;
  logic [WIDTH:0]   add_x, adc_x, sub_x;
  logic             c_in, sa, sb, sc_c, sc_o;
  logic             core_last;
  logic [WIDTH-1:0] core_lo, core_hi;

  assign half = ~bus.FunSel[FS_WIDTH];
  assign grp  = bus.FunSel[FS_GROUP];
  assign op   = bus.FunSel[3:0];
  assign mask = half ? LO_MASK : '1;
  assign msb  = half ? LO_MSB : FULL_MSB;
  assign a_m  = bus.A & mask;
  assign b_m  = bus.B & mask;
  assign sa   = |(a_m & msb);
  assign sb   = |(b_m & msb);
  assign c_in = flags_q[FL_C];

  assign md_valid    = MULDIV_EN && ((op == OP_MUL) || (op == OP_DIV));
  assign is_div0     = grp && md_valid && (op == OP_DIV) && (b_m == '0);
  assign is_reserved = grp && !md_valid;

  // Sums carry one extra bit; the carry/borrow sits at bit E of the result.
  assign add_x = {1'b0, a_m} + {1'b0, b_m};
  assign adc_x = add_x + {{WIDTH{1'b0}}, c_in};
  assign sub_x = {1'b0, a_m} - {1'b0, b_m};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_run  = 1'b0;
    finish_now = 1'b0;
    run_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          if (grp && md_valid && !is_div0) begin
            start_run = 1'b1;
            state_n   = S_RUN;
          end else begin
            finish_now = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (core_last) begin
          run_done = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Single-cycle result; C and O default to their held values so logic
  // ops leave them untouched.
  always_comb begin
    sc_res = '0;
    sc_c   = flags_q[FL_C];
    sc_o   = flags_q[FL_O];
    case (op)
      OP_PASS_A: sc_res = a_m;
      OP_PASS_B: sc_res = b_m;
      OP_NOT_A:  sc_res = ~a_m & mask;
      OP_NOT_B:  sc_res = ~b_m & mask;
      OP_ADD: begin
        sc_res = add_x[WIDTH-1:0] & mask;
        sc_c   = half ? add_x[HW] : add_x[WIDTH];
        sc_o   = add_overflow(sa, sb, |(sc_res & msb));
      end
      OP_ADC: begin
        sc_res = adc_x[WIDTH-1:0] & mask;
        sc_c   = half ? adc_x[HW] : adc_x[WIDTH];
        sc_o   = add_overflow(sa, sb, |(sc_res & msb));
      end
      OP_SUB: begin
        sc_res = sub_x[WIDTH-1:0] & mask;
        sc_c   = half ? sub_x[HW] : sub_x[WIDTH];
        sc_o   = add_overflow(sa, ~sb, |(sc_res & msb));
      end
      OP_AND:  sc_res = a_m & b_m;
      OP_OR:   sc_res = a_m | b_m;
      OP_XOR:  sc_res = a_m ^ b_m;
      OP_NAND: sc_res = ~(a_m & b_m) & mask;
      OP_LSL: begin
        sc_res = (a_m << 1) & mask;
        sc_c   = sa;
      end
      OP_LSR: begin
        sc_res = a_m >> 1;
        sc_c   = a_m[0];
      end
      OP_ASR: begin
        sc_res = (a_m >> 1) | (a_m & msb);
        sc_c   = a_m[0];
      end
      OP_CSL: begin
        sc_res = ((a_m << 1) | {{(WIDTH-1){1'b0}}, c_in}) & mask;
        sc_c   = sa;
      end
      OP_CSR: begin
        sc_res = (a_m >> 1) | (c_in ? msb : '0);
        sc_c   = a_m[0];
      end
      default: sc_res = '0;
    endcase
  end

  assign run_msb = half_r ? LO_MSB : FULL_MSB;
  assign hi_nz   = |core_hi;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alu_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      wf_r    <= 1'b0;
      div_r   <= 1'b0;
      half_r  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_run) begin
        wf_r   <= bus.WF;
        div_r  <= (op == OP_DIV);
        half_r <= half;
      end else if (finish_now) begin
        done_q <= 1'b1;
        if (is_reserved) begin
          alu_q <= '0;
          hi_q  <= '0;
        end else if (is_div0) begin
          // Quotient saturates to all-ones over E; remainder is the dividend.
          alu_q <= mask;
          hi_q  <= a_m;
          if (bus.WF) flags_q <= {1'b0, 1'b0, 1'b1, 1'b1};
        end else begin
          alu_q <= sc_res;
          hi_q  <= '0;
          if (bus.WF) flags_q <= {sc_res == '0, sc_c, |(sc_res & msb), sc_o};
        end
      end else if (run_done) begin
        done_q <= 1'b1;
        alu_q  <= core_lo;
        hi_q   <= core_hi;
        if (wf_r) begin
          flags_q <= {core_lo == '0, hi_nz & ~div_r, |(core_lo & run_msb), hi_nz & ~div_r};
        end
      end
    end
  end

  iterative_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (start_run),
    .run     (state == S_RUN),
    .div_sel (op == OP_DIV),
    .half    (half),
    .a       (a_m),
    .b       (b_m),
    .last    (core_last),
    .res_lo  (core_lo),
    .res_hi  (core_hi)
  );

  assign bus.ALUOut   = alu_q;
  assign bus.HiOut    = hi_q;
  assign bus.FlagsOut = flags_q;
  assign bus.Done     = done_q;
  assign bus.Busy     = (state == S_RUN);
  assign dbg_state    = state;

endmodule
